// File: rtl/riscv_lsu.sv
// Load/store unit: one memory access at a time, IDLE -> REQ -> DONE.
// Ports: core_* from decoder/ALU, mem_* to a single-word memory port.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [31:0] r_rd;
  logic        r_we;
  logic [2:0]  r_size;

  logic        w_start;
  logic        w_fin_ld;
  logic        w_b;
  logic        w_h;
  logic        w_w;
  logic        w_uns;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_ld;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // size decode: bit 2 marks the unsigned variants
  always_comb begin
    w_b   = (r_size == 3'd0) || (r_size == 3'd4);
    w_h   = (r_size == 3'd1) || (r_size == 3'd5);
    w_w   = (r_size == 3'd2);
    w_uns = r_size[2];
  end

  always_comb begin
    w_byte = mem_rd_i[7:0];
    unique case (r_addr[1:0])
      2'd0: w_byte = mem_rd_i[7:0];
      2'd1: w_byte = mem_rd_i[15:8];
      2'd2: w_byte = mem_rd_i[23:16];
      2'd3: w_byte = mem_rd_i[31:24];
      default: w_byte = mem_rd_i[7:0];
    endcase
    w_half = r_addr[1] ? mem_rd_i[31:16]
                       : mem_rd_i[15:0];
  end

  // lane enables, store replication, load formatting
  always_comb begin
    w_be = 4'b0000;
    w_wd = r_wd;
    w_ld = 32'h0;
    unique case (1'b1)
      w_b: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {4{r_wd[7:0]}};
        w_ld = w_uns ? {24'h0, w_byte}
                     : {{24{w_byte[7]}}, w_byte};
      end
      w_h: begin
        w_be = 4'b0011 << {r_addr[1], 1'b0};
        w_wd = {2{r_wd[15:0]}};
        w_ld = w_uns ? {16'h0, w_half}
                     : {{16{w_half[15]}}, w_half};
      end
      w_w: begin
        w_be = 4'b1111;
        w_wd = r_wd;
        w_ld = mem_rd_i;
      end
      default: begin
        w_be = 4'b0000;
        w_wd = r_wd;
        w_ld = 32'h0;
      end
    endcase
  end

  assign w_start  = (r_state == S_IDLE) && core_req_i;
  assign w_fin_ld = (r_state == S_REQ) && mem_ready_i
                    && !r_we;

  always_comb begin
    w_next       = r_state;
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    unique case (r_state)
      S_IDLE: begin
        if (core_req_i) w_next = S_REQ;
        core_stall_o = core_req_i;
      end
      S_REQ: begin
        if (mem_ready_i) w_next = S_DONE;
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = r_we;
        mem_be_o     = w_be;
      end
      // a request still high here belongs to the finished access
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (rst_i) begin
      core_stall_o = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_be_o     = 4'b0000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= 32'h0;
      r_wd    <= 32'h0;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_rd    <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr <= core_addr_i;
        r_wd   <= core_wd_i;
        r_we   <= core_we_i;
        r_size <= core_size_i;
      end
      if (w_fin_ld) r_rd <= w_ld;
    end
  end

  assign core_rd_o  = r_rd;
  assign mem_addr_o = {r_addr[31:2], 2'b00};
  assign mem_wd_o   = w_wd;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: vector table plus
// hand-written wait-state, reset and back-to-back sequences.
module tb_riscv_lsu;

  logic        clk_i;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  riscv_lsu dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv[15];
  int   total = 0;
  int   bad   = 0;
  int   req_cyc = 0;

  always @(negedge clk_i) if (mem_req_o) req_cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [2:0] sz,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rd, input logic [31:0] ea,
    input logic [3:0] eb, input logic [31:0] ew,
    input logic [31:0] er);
    vec_t v;
    v.we = we; v.size = sz; v.addr = a; v.wd = wd;
    v.rd = rd; v.e_addr = ea; v.e_be = eb;
    v.e_wd = ew; v.e_rd = er;
    return v;
  endfunction

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    core_req_i  = 1'b1;
    core_we_i   = v.we;
    core_size_i = v.size;
    core_addr_i = v.addr;
    core_wd_i   = v.wd;
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'h0;
    @(negedge clk_i);
    chk($sformatf("v%0d_idle_stall", i),
        {31'h0, core_stall_o}, 32'h1);
    chk($sformatf("v%0d_idle_req", i),
        {31'h0, mem_req_o}, 32'h0);
    nxt();
    core_addr_i = ~v.addr;
    core_wd_i   = ~v.wd;
    core_we_i   = ~v.we;
    mem_ready_i = 1'b1;
    mem_rd_i    = v.rd;
    @(negedge clk_i);
    chk($sformatf("v%0d_req", i),
        {31'h0, mem_req_o}, 32'h1);
    chk($sformatf("v%0d_stall", i),
        {31'h0, core_stall_o}, 32'h1);
    chk($sformatf("v%0d_we", i),
        {31'h0, mem_we_o}, {31'h0, v.we});
    chk($sformatf("v%0d_be", i),
        {28'h0, mem_be_o}, {28'h0, v.e_be});
    chk($sformatf("v%0d_addr", i), mem_addr_o, v.e_addr);
    if (v.we)
      chk($sformatf("v%0d_wd", i), mem_wd_o, v.e_wd);
    nxt();
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'hFFFF_FFFF;
    @(negedge clk_i);
    chk($sformatf("v%0d_done_stall", i),
        {31'h0, core_stall_o}, 32'h0);
    chk($sformatf("v%0d_done_req", i),
        {31'h0, mem_req_o}, 32'h0);
    chk($sformatf("v%0d_rd", i), core_rd_o, v.e_rd);
    nxt();
    core_req_i = 1'b0;
    @(negedge clk_i);
    chk($sformatf("v%0d_norestart", i),
        {31'h0, mem_req_o}, 32'h0);
    chk($sformatf("v%0d_rd_hold", i), core_rd_o, v.e_rd);
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int sc;
    int rc;
    tv[0]  = mk(0, 3'd2, 32'h104, 0, 32'hDEADBEEF,
                32'h104, 4'b1111, 0, 32'hDEADBEEF);
    tv[1]  = mk(1, 3'd1, 32'h0A2, 32'h1234ABCD, 32'h5A5A5A5A,
                32'h0A0, 4'b1100, 32'hABCDABCD, 32'hDEADBEEF);
    tv[2]  = mk(0, 3'd0, 32'h003, 0, 32'h80112233,
                32'h000, 4'b1000, 0, 32'hFFFFFF80);
    tv[3]  = mk(0, 3'd4, 32'h003, 0, 32'h80112233,
                32'h000, 4'b1000, 0, 32'h00000080);
    tv[4]  = mk(0, 3'd1, 32'h002, 0, 32'h80017FFF,
                32'h000, 4'b1100, 0, 32'hFFFF8001);
    tv[5]  = mk(0, 3'd5, 32'h000, 0, 32'h8001FFFF,
                32'h000, 4'b0011, 0, 32'h0000FFFF);
    tv[6]  = mk(0, 3'd0, 32'h001, 0, 32'h12345678,
                32'h000, 4'b0010, 0, 32'h00000056);
    tv[7]  = mk(1, 3'd0, 32'h002, 32'h000000A5, 0,
                32'h000, 4'b0100, 32'hA5A5A5A5, 32'h00000056);
    tv[8]  = mk(1, 3'd2, 32'h008, 32'hCAFEF00D, 0,
                32'h008, 4'b1111, 32'hCAFEF00D, 32'h00000056);
    tv[9]  = mk(0, 3'd1, 32'h003, 0, 32'hABCD1234,
                32'h000, 4'b1100, 0, 32'hFFFFABCD);
    tv[10] = mk(0, 3'd4, 32'h002, 0, 32'h00FF0000,
                32'h000, 4'b0100, 0, 32'h000000FF);
    tv[11] = mk(0, 3'd3, 32'h004, 0, 32'hFFFFFFFF,
                32'h004, 4'b0000, 0, 32'h00000000);
    tv[12] = mk(0, 3'd0, 32'h100, 0, 32'h0000007F,
                32'h100, 4'b0001, 0, 32'h0000007F);
    tv[13] = mk(0, 3'd6, 32'h007, 0, 32'h12345678,
                32'h004, 4'b0000, 0, 32'h00000000);
    tv[14] = mk(0, 3'd2, 32'hFFFFFFFE, 0, 32'h0BADF00D,
                32'hFFFFFFFC, 4'b1111, 0, 32'h0BADF00D);

    rst_i       = 1'b1;
    core_req_i  = 1'b1;
    core_we_i   = 1'b1;
    core_size_i = 3'd2;
    core_addr_i = 32'h104;
    core_wd_i   = 32'h55;
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b1;
    repeat (3) nxt();
    @(negedge clk_i);
    chk("rst_stall", {31'h0, core_stall_o}, 32'h0);
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_we", {31'h0, mem_we_o}, 32'h0);
    chk("rst_be", {28'h0, mem_be_o}, 32'h0);
    chk("rst_rd", core_rd_o, 32'h0);
    nxt();
    rst_i = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, tv[i]);

    // LHU with three wait states, address changed mid-wait
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd5;
    core_addr_i = 32'h10;
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'h55555555;
    sc = 0;
    rc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (core_stall_o) sc++;
      if (mem_req_o) begin
        rc++;
        chk($sformatf("ws_addr_c%0d", c), mem_addr_o, 32'h10);
      end
      if (c == 2) chk("ws_rd_hold", core_rd_o, 32'h0BADF00D);
      nxt();
      core_addr_i = 32'h200;
      mem_ready_i = (c + 1 == 4);
      mem_rd_i    = (c + 1 == 4) ? 32'h77779ABC : 32'h55555555;
      if (c + 1 >= 6) core_req_i = 1'b0;
    end
    chk("ws_stall_cycles", sc, 5);
    chk("ws_req_cycles", rc, 4);
    chk("ws_rd", core_rd_o, 32'h00009ABC);

    // reset while waiting in REQ
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h20;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    nxt();
    @(negedge clk_i);
    chk("rr_in_req", {31'h0, mem_req_o}, 32'h1);
    nxt();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rr_req_forced", {31'h0, mem_req_o}, 32'h0);
    chk("rr_stall_forced", {31'h0, core_stall_o}, 32'h0);
    nxt();
    rst_i      = 1'b0;
    core_req_i = 1'b0;
    @(negedge clk_i);
    chk("rr_req_after", {31'h0, mem_req_o}, 32'h0);
    chk("rr_stall_after", {31'h0, core_stall_o}, 32'h0);
    chk("rr_rd_cleared", core_rd_o, 32'h0);
    nxt();
    core_req_i  = 1'b1;
    core_we_i   = 1'b1;
    core_size_i = 3'd0;
    core_addr_i = 32'h1;
    core_wd_i   = 32'h3C;
    @(negedge clk_i);
    chk("sb_stall", {31'h0, core_stall_o}, 32'h1);
    nxt();
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("sb_req", {31'h0, mem_req_o}, 32'h1);
    chk("sb_we", {31'h0, mem_we_o}, 32'h1);
    chk("sb_be", {28'h0, mem_be_o}, 32'h2);
    chk("sb_wd", mem_wd_o, 32'h3C3C3C3C);
    nxt();
    mem_ready_i = 1'b0;
    core_req_i  = 1'b0;
    @(negedge clk_i);
    chk("sb_done_stall", {31'h0, core_stall_o}, 32'h0);
    chk("sb_rd", core_rd_o, 32'h0);
    nxt();

    // back-to-back LW then SW
    @(negedge clk_i);
    req_cyc = 0;
    nxt();
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h40;
    @(negedge clk_i);
    nxt();
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'h11223344;
    @(negedge clk_i);
    chk("bb_lw_req", {31'h0, mem_req_o}, 32'h1);
    nxt();
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("bb_done_req", {31'h0, mem_req_o}, 32'h0);
    chk("bb_lw_rd", core_rd_o, 32'h11223344);
    nxt();
    core_we_i   = 1'b1;
    core_addr_i = 32'h44;
    core_wd_i   = 32'h99;
    @(negedge clk_i);
    chk("bb_idle_stall", {31'h0, core_stall_o}, 32'h1);
    chk("bb_idle_req", {31'h0, mem_req_o}, 32'h0);
    nxt();
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bb_sw_req", {31'h0, mem_req_o}, 32'h1);
    chk("bb_sw_we", {31'h0, mem_we_o}, 32'h1);
    chk("bb_sw_addr", mem_addr_o, 32'h44);
    chk("bb_sw_wd", mem_wd_o, 32'h99);
    nxt();
    mem_ready_i = 1'b0;
    core_req_i  = 1'b0;
    @(negedge clk_i);
    chk("bb_sw_rd", core_rd_o, 32'h11223344);
    nxt();
    @(negedge clk_i);
    nxt();
    chk("bb_req_cycles", req_cyc, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
